// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter (LSB first, idle high).
// A new frame starts as soon as a byte is queued and the previous stop bit ends.
module uart_tx_fifo #(
  parameter int CLOCKS_PER_BAUD = 694,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        wr_valid_i,
  input  logic [7:0]                  wr_data_i,
  output logic                        wr_ready_o,
  output logic                        uart_tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  state_t            state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [2:0]        bit_idx_reg, bit_idx_next;
  logic [7:0]        tx_shift_reg, tx_shift_next;
  logic              tx_reg, tx_next;
  logic              push, pop, fifo_empty, baud_done;

  assign fifo_empty = (count_reg == '0);
  assign baud_done  = (baud_reg == BAUD_LAST);

  // Ready depends only on the registered count, so a pop cannot free a slot
  // for a push in the same cycle.
  assign wr_ready_o = rstn_i && (count_reg != FULL_COUNT);
  assign push       = wr_valid_i && wr_ready_o;

  assign uart_tx_o    = tx_reg;
  assign busy_o       = (state_reg != IDLE) || !fifo_empty;
  assign fifo_count_o = count_reg;

  always_comb begin
    state_next    = state_reg;
    baud_next     = baud_reg;
    bit_idx_next  = bit_idx_reg;
    tx_shift_next = tx_shift_reg;
    tx_next       = 1'b1;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          tx_shift_next = fifo_mem[rd_ptr_reg];
          baud_next     = '0;
          bit_idx_next  = '0;
          state_next    = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_done) begin
          baud_next    = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      DATA: begin
        tx_next = tx_shift_reg[0];
        if (baud_done) begin
          baud_next     = '0;
          tx_shift_next = {1'b0, tx_shift_reg[7:1]};
          bit_idx_next  = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (baud_done) begin
          baud_next    = '0;
          bit_idx_next = '0;
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            pop           = 1'b1;
            tx_shift_next = fifo_mem[rd_ptr_reg];
            state_next    = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_reg    <= IDLE;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      baud_reg     <= '0;
      bit_idx_reg  <= '0;
      tx_shift_reg <= '0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      baud_reg     <= baud_next;
      bit_idx_reg  <= bit_idx_next;
      tx_shift_reg <= tx_shift_next;
      tx_reg       <= tx_next;
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= wr_data_i;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue/frame-timer reference model with
// per-cycle compare, a serial decoder, and directed literal checks.
module tb_uart_tx_fifo;

  localparam int A_CPB   = 16;
  localparam int A_DEPTH = 8;
  localparam int A_FRAME = 10 * A_CPB;
  localparam int B_CPB   = 2;
  localparam int B_DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn    = 1'b0;
  logic       a_valid = 1'b0;
  logic [7:0] a_data  = 8'h00;
  logic       a_ready, a_tx, a_busy;
  logic [3:0] a_count;
  logic       b_valid = 1'b0;
  logic [7:0] b_data  = 8'h00;
  logic       b_ready, b_tx, b_busy;
  logic [1:0] b_count;

  uart_tx_fifo #(.CLOCKS_PER_BAUD(A_CPB), .FIFO_DEPTH(A_DEPTH)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .wr_valid_i(a_valid), .wr_data_i(a_data),
    .wr_ready_o(a_ready), .uart_tx_o(a_tx), .busy_o(a_busy), .fifo_count_o(a_count)
  );

  uart_tx_fifo #(.CLOCKS_PER_BAUD(B_CPB), .FIFO_DEPTH(B_DEPTH)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .wr_valid_i(b_valid), .wr_data_i(b_data),
    .wr_ready_o(b_ready), .uart_tx_o(b_tx), .busy_o(b_busy), .fifo_count_o(b_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: byte queue plus a frame timer counting cycles since the pop.
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_t      = 0;
  logic [7:0] m_byte   = 8'h00;
  logic       m_tx     = 1'b1;

  function automatic logic line_bit(input bit act, input int t, input logic [7:0] b);
    int k;
    if (!act) return 1'b1;
    k = t / A_CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    logic nt;
    bit   rdy;
    if (!rstn) begin
      m_q.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_tx     = 1'b1;
    end else begin
      rdy = (m_q.size() != A_DEPTH);
      nt  = line_bit(m_active, m_t, m_byte);
      if (m_active && m_t == A_FRAME - 1) m_active = 1'b0;
      else if (m_active) m_t++;
      if (!m_active && m_q.size() != 0) begin
        m_byte   = m_q.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end
      if (a_valid && rdy) m_q.push_back(a_data);
      m_tx = nt;
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_tx",    32'(a_tx),    32'(m_tx));
      check("model_count", 32'(a_count), 32'(m_q.size()));
      check("model_busy",  32'(a_busy),  32'(m_active || m_q.size() != 0));
      check("model_ready", 32'(a_ready), 32'(rstn && m_q.size() != A_DEPTH));
    end
  end

  // Serial decoder for instance A, sampling mid-bit.
  logic [7:0] dec_q[$];
  bit         dec_active = 1'b0;
  int         dec_cnt    = 0;
  logic [7:0] dec_sh     = 8'h00;
  always @(negedge clk) begin
    if (!rstn) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (a_tx === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt >= 24 && dec_cnt <= 136 && ((dec_cnt - 8) % 16) == 0)
        dec_sh[(dec_cnt - 24) / 16] = a_tx;
      if (dec_cnt == 152) begin
        dec_active = 1'b0;
        dec_q.push_back(dec_sh);
      end
    end
  end

  task automatic wait_a_count_ne(input int v, input int maxc, input string name);
    int i;
    i = 0;
    while (a_count == 4'(v) && i < maxc) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(a_count != 4'(v)), 32'd1);
  endtask

  task automatic wait_a_idle(input int maxc, input string name);
    int i;
    i = 0;
    while (a_busy && i < maxc) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(a_busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat55;
    logic [9:0] patb;
    logic [7:0] sent_q[$];
    int  k, acc_before_drop, guard, n;
    bit  acc, saw_low;
    logic exp_b;

    pat55 = {1'b1, 8'h55, 1'b0};
    patb  = {1'b1, 8'hC5, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready_low", 32'(a_ready), 32'd0);
    @(posedge clk); #2;
    rstn = 1'b1;
    @(negedge clk);
    check("rst_tx",    32'(a_tx),    32'd1);
    check("rst_count", 32'(a_count), 32'd0);
    check("rst_busy",  32'(a_busy),  32'd0);
    check("rst_ready", 32'(a_ready), 32'd1);

    // Single 0x55 frame with exact latency and bit timing
    @(posedge clk); #2;
    a_valid = 1'b1; a_data = 8'h55;
    @(posedge clk); #2;
    a_valid = 1'b0; a_data = 8'hFF;
    @(negedge clk);
    check("p55_count_after_push", 32'(a_count), 32'd1);
    @(negedge clk);
    check("p55_tx_at_pop", 32'(a_tx),    32'd1);
    check("p55_popped",    32'(a_count), 32'd0);
    check("p55_busy",      32'(a_busy),  32'd1);
    @(negedge clk);
    check("p55_start_edge", 32'(a_tx), 32'd0);
    for (int b = 0; b < 10; b++) begin
      repeat ((b == 0) ? 8 : 16) @(negedge clk);
      check("p55_bit", 32'(a_tx), 32'(pat55[b]));
    end
    repeat (6) @(negedge clk);
    check("p55_busy_last", 32'(a_busy), 32'd1);
    @(negedge clk);
    check("p55_busy_fall", 32'(a_busy), 32'd0);

    // Hold valid with 0x00..0x09 while idle
    @(posedge clk); #2;
    k = 0; acc_before_drop = -1; guard = 0;
    while (k < 10 && guard < 2000) begin
      a_valid = 1'b1; a_data = 8'(k);
      @(negedge clk);
      acc = a_ready;
      if (!acc && acc_before_drop < 0) acc_before_drop = k;
      @(posedge clk); #2;
      if (acc) k++;
      guard++;
    end
    a_valid = 1'b1; a_data = 8'h0A;
    @(negedge clk);
    check("c030_all_accepted",   32'(k), 32'd10);
    check("c030_accepts_before", 32'(acc_before_drop), 32'd9);
    check("c030_count_after_09", 32'(a_count), 32'd8);

    // Full: push during pop is refused, count drops to 7
    wait_a_count_ne(8, 400, "c031_wait_pop_full");
    check("c031_full_pop_reject", 32'(a_count), 32'd7);
    @(posedge clk); #2;
    a_valid = 1'b0;
    @(negedge clk);
    check("c031_refill", 32'(a_count), 32'd8);

    // Count 7: push on the pop edge keeps count at 7
    wait_a_count_ne(8, 400, "c031_wait_pop");
    repeat (159) @(posedge clk);
    #2;
    a_valid = 1'b1; a_data = 8'h0B;
    @(negedge clk);
    check("c031_pre_pop", 32'(a_count), 32'd7);
    @(posedge clk); #2;
    a_valid = 1'b0;
    @(negedge clk);
    check("c031_push_pop_hold", 32'(a_count), 32'd7);
    wait_a_idle(3000, "c030_drain");

    // 20 random pushes with random gaps; decoded stream must match
    dec_q.delete();
    @(posedge clk); #2;
    n = 0; guard = 0;
    while (n < 20 && guard < 20000) begin
      a_valid = (n < 10) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) != 0);
      a_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (a_valid && a_ready) begin
        sent_q.push_back(a_data);
        n++;
      end
      @(posedge clk); #2;
      guard++;
    end
    a_valid = 1'b0;
    @(negedge clk);
    wait_a_idle(5000, "c032_drain");
    repeat (20) @(negedge clk);
    check("c032_pushed",  32'(n), 32'd20);
    check("c032_decoded", 32'(dec_q.size()), 32'(sent_q.size()));
    for (int i = 0; i < sent_q.size(); i++) begin
      if (i < dec_q.size()) check("c032_byte", 32'(dec_q[i]), 32'(sent_q[i]));
    end

    // Reset during DATA bit 3 of 0xA3 with 3 bytes queued
    @(posedge clk); #2;
    a_valid = 1'b1; a_data = 8'hA3;
    @(posedge clk); #2; a_data = 8'h11;
    @(posedge clk); #2; a_data = 8'h22;
    @(posedge clk); #2; a_data = 8'h33;
    @(posedge clk); #2;
    a_valid = 1'b0;
    repeat (69) @(posedge clk);
    #2;
    @(negedge clk);
    check("c033_queued", 32'(a_count), 32'd3);
    check("c033_bit3",   32'(a_tx),    32'd0);
    @(posedge clk); #2;
    rstn = 1'b0; a_valid = 1'b1; a_data = 8'hEE;
    @(negedge clk);
    check("c033_ready_in_rst", 32'(a_ready), 32'd0);
    @(posedge clk); #2;
    rstn = 1'b1; a_valid = 1'b0;
    @(negedge clk);
    check("c033_tx",    32'(a_tx),    32'd1);
    check("c033_count", 32'(a_count), 32'd0);
    check("c033_busy",  32'(a_busy),  32'd0);
    saw_low = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (a_tx !== 1'b1) saw_low = 1'b1;
    end
    check("c033_no_frames", 32'(saw_low), 32'd0);

    // CLOCKS_PER_BAUD=2 instance: 0xC5 frame, 2 cycles per bit
    @(posedge clk); #2;
    b_valid = 1'b1; b_data = 8'hC5;
    @(posedge clk); #2;
    b_valid = 1'b0; b_data = 8'h00;
    for (int j = 0; j <= 24; j++) begin
      @(negedge clk);
      exp_b = (j >= 2 && j <= 21) ? patb[(j - 2) / 2] : 1'b1;
      check("c034_tx", 32'(b_tx), 32'(exp_b));
      if (j == 0)  check("c034_count", 32'(b_count), 32'd1);
      if (j == 20) check("c034_busy_last", 32'(b_busy), 32'd1);
      if (j == 21) check("c034_busy_fall", 32'(b_busy), 32'd0);
    end
    check("c034_ready", 32'(b_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
